// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and FSM state type for the mac_accum dot-product accumulator.
package mac_pkg;

  localparam int unsigned PROD_W    = 10;
  localparam int unsigned MAX_TERMS = 16;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ACC_W     = 14;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with overflow detect; clamps to the signed range when MAC_ACCUM_SATURATE_EN is defined.
module sat_add #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign that the result lost.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef MAC_ACCUM_SATURATE_EN
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  assign sum = ovf ? (a[W-1] ? SMIN : SMAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/mac_accum.sv
// Sequential dot-product accumulator with a valid/ready result port.
// Optional saturating arithmetic and sticky overflow error via MAC_ACCUM_SATURATE_EN.
module mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W    = mac_pkg::PROD_W,
  parameter int unsigned MAX_TERMS = mac_pkg::MAX_TERMS,
  parameter int unsigned CNT_W     = mac_pkg::CNT_W,
  parameter int unsigned ACC_W     = mac_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               close;
  logic               ovf;
  logic               add_ovf;
  logic               sat_flag;
  logic               vec_sat;

  assign prod_ext = ACC_W'($signed(in_prod));
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign close    = in_last || (cnt_nxt == CNT_W'(MAX_TERMS));

  sat_add #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (acc_sum),
    .ovf (ovf)
  );

`ifdef MAC_ACCUM_SATURATE_EN
  assign add_ovf = ovf;
`else
  // Wrap-around build: overflow never contributes to err.
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign add_ovf    = 1'b0;
`endif

  assign vec_sat = sat_flag || add_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat_flag  <= 1'b0;
      acc_out   <= '0;
      term_cnt  <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (close) begin
              acc_out   <= acc_sum;
              term_cnt  <= cnt_nxt;
              err       <= !in_last || vec_sat;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              sat_flag  <= 1'b0;
              state     <= DONE;
            end else begin
              acc      <= acc_sum;
              cnt      <= cnt_nxt;
              sat_flag <= vec_sat;
            end
          end
        end
        DONE: begin
          // Result held stable until downstream takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum: directed vectors push expected results, negedge monitors pop and compare.
module tb_mac_accum;

  typedef struct {
    logic [13:0] acc;
    logic [4:0]  cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic [9:0] acc;
    logic [4:0] cnt;
    logic       err;
  } exp10_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  in_prod;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [13:0] acc_out;
  logic [4:0]  term_cnt;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  logic [9:0]  s_prod;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [9:0]  s_acc;
  logic [4:0]  s_cnt;
  logic        s_err;
  logic        s_ovalid;
  logic        s_oready;

  int nvec = 0;
  int nerr = 0;
  exp_t   exp_q[$];
  exp10_t exp10_q[$];

  always #5 clk = ~clk;

  mac_accum dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_out(acc_out), .term_cnt(term_cnt), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mac_accum #(.ACC_W(10)) dut10 (
    .clk(clk), .rst(rst), .in_prod(s_prod), .in_valid(s_valid), .in_last(s_last),
    .in_ready(s_ready), .acc_out(s_acc), .term_cnt(s_cnt), .err(s_err),
    .out_valid(s_ovalid), .out_ready(s_oready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge, away from both sampling points.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [9:0] p, input logic l);
    int n;
    n = 0;
    in_prod  = p;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [13:0] a, input logic [4:0] c, input logic e);
    exp_t x;
    x.acc = a;
    x.cnt = c;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Main-DUT monitor: one comparison set per handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("acc_out", 32'(acc_out), 32'(e.acc));
        check("term_cnt", 32'(term_cnt), 32'(e.cnt));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  // Narrow-accumulator monitor.
  always @(negedge clk) begin
    if (!rst && s_ovalid && s_oready) begin
      if (exp10_q.size() == 0) begin
        check("unexpected_result10", 32'(s_ovalid), 32'(0));
      end else begin
        exp10_t e;
        e = exp10_q.pop_front();
        check("acc10", 32'(s_acc), 32'(e.acc));
        check("cnt10", 32'(s_cnt), 32'(e.cnt));
        check("err10", 32'(s_err), 32'(e.err));
      end
    end
  end

  initial begin
    int n;
    exp10_t e10;
    rst = 1'b1; in_prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    s_prod = '0; s_valid = 1'b0; s_last = 1'b0; s_oready = 1'b1;
    tick(); tick();
    check("rst_acc", 32'(acc_out), 32'(0));
    check("rst_cnt", 32'(term_cnt), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_oval", 32'(out_valid), 32'(0));
    check("rst_inrdy", 32'(in_ready), 32'(1));
    rst = 1'b0;
    tick();

    // 256 - 240 + 15 = 31
    push(14'd31, 5'd3, 1'b0);
    send(10'h100, 1'b0);
    send(10'h310, 1'b0);
    send(10'h00F, 1'b1);
    check("latency_oval", 32'(out_valid), 32'(1));
    check("done_inrdy", 32'(in_ready), 32'(0));
    tick();

    // Single beat of -1
    push(14'h3FFF, 5'd1, 1'b0);
    send(10'h3FF, 1'b1);
    tick();

    // 16 x 256 without in_last, result held for 5 cycles while a 17th beat waits
    out_ready = 1'b0;
    push(14'd4096, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) send(10'h100, 1'b0);
    in_prod = 10'h100; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_inrdy", 32'(in_ready), 32'(0));
      check("hold_oval", 32'(out_valid), 32'(1));
      check("hold_acc", 32'(acc_out), 32'(4096));
      check("hold_cnt", 32'(term_cnt), 32'(16));
      check("hold_err", 32'(err), 32'(1));
      tick();
    end
    out_ready = 1'b1;
    push(14'd256, 5'd1, 1'b0);
    send(10'h100, 1'b1);
    tick();

    // in_last exactly on the 16th beat closes normally
    push(14'd16, 5'd16, 1'b0);
    for (int i = 0; i < 15; i++) send(10'h001, 1'b0);
    send(10'h001, 1'b1);
    tick();

    // Reset after two accepted beats discards the partial sum
    send(10'd100, 1'b0);
    send(10'd50, 1'b0);
    rst = 1'b1;
    tick();
    check("midrst_inrdy", 32'(in_ready), 32'(1));
    check("midrst_oval", 32'(out_valid), 32'(0));
    rst = 1'b0;
    push(14'd12, 5'd2, 1'b0);
    send(10'd5, 1'b0);
    send(10'd7, 1'b1);
    tick();

    // Reset while a result is pending in DONE drops it
    out_ready = 1'b0;
    send(10'd9, 1'b1);
    rst = 1'b1;
    tick();
    check("donerst_oval", 32'(out_valid), 32'(0));
    check("donerst_acc", 32'(acc_out), 32'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // ACC_W=10: 3 x 256 either saturates or wraps
`ifdef MAC_ACCUM_SATURATE_EN
    e10.acc = 10'd511; e10.err = 1'b1;
`else
    e10.acc = 10'h300; e10.err = 1'b0;
`endif
    e10.cnt = 5'd3;
    exp10_q.push_back(e10);
    s_prod = 10'h100; s_valid = 1'b1; s_last = 1'b0;
    tick(); tick();
    s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    check("latency_oval10", 32'(s_ovalid), 32'(1));

    n = 0;
    while ((exp_q.size() != 0 || exp10_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(exp_q.size() + exp10_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
